// File: rtl/imem_loader_pkg.sv
// Shared definitions for the serial instruction-memory loader.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: loader FSM state encoding, frame header byte, byte-lane placement
// of received bytes within a 32-bit instruction word (little-endian).
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Byte k of a word lands in bits [8k+7:8k]; lane 3 completes the word.
  localparam logic [1:0] LAST_LANE = 2'd3;

  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_uart_rx_byte.sv
// UART 8N1 byte receiver: synchroniser, mid-bit sampler, LSB-first shifter.
// Latency: byte_valid/framing_error pulse one cycle after the stop-bit mid-sample.
// Backpressure: none; the line cannot be stalled, each byte is presented once.
// Ports: clk, reset (sync, active-high), uart_rx (async line, idle high);
//        byte_valid (1-cycle pulse), byte_data (held until next byte),
//        framing_error (1-cycle pulse when the stop bit reads 0; byte dropped).
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_error
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t      rx_state, rx_nxt;
  logic           rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           tick_half, tick_full;

  assign tick_half = (cnt == CW'(HALF - 1));
  assign tick_full = (cnt == CW'(CLKS_PER_BIT - 1));
  assign byte_data = shreg;

  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_nxt = RX_START;
      // A start bit that has gone high again by its mid-point was a glitch.
      RX_START: if (tick_half) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_idx == 3'd7) rx_nxt = RX_STOP;
      RX_STOP:  if (tick_full) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state      <= RX_IDLE;
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_state      <= rx_nxt;
      rx_meta       <= uart_rx;
      rx_sync       <= rx_meta;
      rx_prev       <= rx_sync;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;

      // Timer restarts on every state change and at each full bit period,
      // so after the half-bit start check all samples fall at mid-bit.
      if (rx_nxt != rx_state || tick_full) cnt <= '0;
      else if (rx_state != RX_IDLE)        cnt <= cnt + 1'b1;

      case (rx_state)
        RX_IDLE: bit_idx <= '0;
        RX_DATA: if (tick_full) begin
          shreg   <= {rx_sync, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        RX_STOP: if (tick_full) begin
          byte_valid    <= rx_sync;
          framing_error <= !rx_sync;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: UART frames -> instruction-memory write port, holds CPU fetch.
// Latency: imem_we one cycle after the byte_valid of a word's 4th byte; state one cycle after byte_valid.
// Backpressure: none; memory accepts every strobe, UART bytes are consumed as they arrive.
// Ports: clk, reset (sync, active-high), uart_rx (8N1 line);
//        imem_we/imem_addr/imem_wdata (memory write port), cpu_hold, load_done, load_error.
// Frame: 0xA5, count lo, count hi, count x 4 data bytes (LE words), [checksum].
// Build option IMEM_LOADER_CHECKSUM_EN: adds the trailing XOR checksum byte and its check;
// without it, DONE follows the last word's write strobe.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [31:0] DEPTH        = 32'd1 << ADDR_WIDTH;

  logic        byte_valid, framing_error;
  logic [7:0]  byte_data;
  state_t      state, state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] words_rem;
  logic [1:0]  byte_lane;
  logic [31:0] word_buf;
  logic [31:0] frame_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .framing_error (framing_error)
  );

  // Full word count as seen while the high count byte is on byte_data.
  assign frame_len = {16'd0, byte_data, len_lo};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (byte_valid && byte_data == FRAME_HDR) state_nxt = S_LEN_LO;
      S_LEN_LO:
        if (framing_error)   state_nxt = S_ERROR;
        else if (byte_valid) state_nxt = S_LEN_HI;
      S_LEN_HI:
        if (framing_error) state_nxt = S_ERROR;
        else if (byte_valid) begin
          if (frame_len > DEPTH)     state_nxt = S_ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
          else if (frame_len == '0)  state_nxt = S_CSUM;
`else
          else if (frame_len == '0)  state_nxt = S_DONE;
`endif
          else                       state_nxt = S_DATA;
        end
      S_DATA:
        if (framing_error) state_nxt = S_ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else if (byte_valid && byte_lane == LAST_LANE && words_rem == 16'd1)
          state_nxt = S_CSUM;
`else
        // words_rem is already decremented during the last word's strobe.
        else if (imem_we && words_rem == 16'd0)
          state_nxt = S_DONE;
`endif
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:
        if (framing_error)   state_nxt = S_ERROR;
        else if (byte_valid) state_nxt = (byte_data == csum) ? S_DONE : S_ERROR;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      len_lo     <= '0;
      words_rem  <= '0;
      byte_lane  <= '0;
      word_buf   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state   <= state_nxt;
      imem_we <= 1'b0;

      // Skip the increment after the final word so a DEPTH-word frame never wraps.
      if (imem_we && words_rem != 16'd0) imem_addr <= imem_addr + 1'b1;

      case (state)
        S_IDLE, S_DONE, S_ERROR:
          if (byte_valid && byte_data == FRAME_HDR) begin
            imem_addr <= '0;
            byte_lane <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        S_LEN_LO: if (byte_valid) len_lo <= byte_data;
        S_LEN_HI: if (byte_valid) words_rem <= {byte_data, len_lo};
        S_DATA:
          if (byte_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            word_buf  <= lane_insert(word_buf, byte_lane, byte_data);
            byte_lane <= byte_lane + 1'b1;
            if (byte_lane == LAST_LANE) begin
              imem_we    <= 1'b1;
              imem_wdata <= lane_insert(word_buf, LAST_LANE, byte_data);
              words_rem  <= words_rem - 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

  assign cpu_hold   = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA) ||
                      (state == S_CSUM)   || (state == S_ERROR);
  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERROR);

endmodule
